// File: rtl/int_ctrl_n.sv
// int_ctrl_n: fixed-priority interrupt controller with synchronised, edge-latched requests.
// Macro INT_NEST_EN enables nested preemption; without it only one handler is ever in service.
module int_ctrl_n #(
  parameter int NUM_SRC     = 3,
  parameter int SYNC_STAGES = 2,
  localparam int CODE_W     = $clog2(NUM_SRC + 1)
) (
  input  logic               clk,
  input  logic               in_RST,
  input  logic [NUM_SRC-1:0] req,
  input  logic               ie,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               ack,
  input  logic               eret,
  output logic               irq,
  output logic [CODE_W-1:0]  code,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service
);

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] edge_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] isr_q, isr_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [CODE_W-1:0]  win, cur;
  logic               irq_w;

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign elig = pend_q & ~mask;

  // Ascending scan so the highest set index is the one left standing.
  always_comb begin
    win = '0;
    cur = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i])  win = CODE_W'(i + 1);
      if (isr_q[i]) cur = CODE_W'(i + 1);
    end
  end

`ifdef INT_NEST_EN
  assign irq_w = ie & (win > cur);
`else
  assign irq_w = ie & (win != '0) & (cur == '0);
`endif

  assign irq        = irq_w;
  assign code       = irq_w ? win : '0;
  assign pending    = pend_q;
  assign in_service = isr_q;

  // eret is applied before ack; a fresh edge overrides an ack clearing the same pending bit.
  always_comb begin
    pend_d = pend_q;
    isr_d  = isr_q;
    if (eret) begin
`ifdef INT_NEST_EN
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cur == CODE_W'(i + 1)) isr_d[i] = 1'b0;
      end
`else
      isr_d = '0;
`endif
    end
    if (ack && irq_w) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (win == CODE_W'(i + 1)) begin
          pend_d[i] = 1'b0;
          isr_d[i]  = 1'b1;
        end
      end
    end
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk or negedge in_RST) begin
    if (!in_RST) begin
      sync_q <= '0;
      edge_q <= '0;
      pend_q <= '0;
      isr_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
      edge_q <= sync_q[SYNC_STAGES-1];
      pend_q <= pend_d;
      isr_q  <= isr_d;
    end
  end

endmodule

// File: tb/tb_int_ctrl_n.sv
// Directed bench for int_ctrl_n (NUM_SRC=3, SYNC_STAGES=2); expectations follow INT_NEST_EN.
module tb_int_ctrl_n;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic       ie;
  logic [2:0] mask;
  logic       ack;
  logic       eret;
  logic       irq;
  logic [1:0] code;
  logic [2:0] pending;
  logic [2:0] in_service;

  int passes;
  int total;

  int_ctrl_n #(.NUM_SRC(3), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .in_RST     (rst_n),
    .req        (req),
    .ie         (ie),
    .mask       (mask),
    .ack        (ack),
    .eret       (eret),
    .irq        (irq),
    .code       (code),
    .pending    (pending),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1;
    tick(1);
    eret = 1'b0;
  endtask

  initial begin
    passes = 0;
    total  = 0;
    rst_n = 1'b0; req = 3'b000; ie = 1'b1; mask = 3'b000; ack = 1'b0; eret = 1'b0;
    tick(2);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_code", {30'd0, code}, 32'd0);
    chk("rst_pending", {29'd0, pending}, 32'd0);
    chk("rst_insvc", {29'd0, in_service}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Latency: req[1] sampled high at edges 1..3; pending visible after edge 3.
    req = 3'b010;
    tick(2);
    chk("lat_pend_e2", {29'd0, pending}, 32'd0);
    tick(1);
    chk("lat_pend_e3", {29'd0, pending}, 32'h2);
    chk("lat_irq", {31'd0, irq}, 32'd1);
    chk("lat_code", {30'd0, code}, 32'd2);
    rst_n = 1'b0;
    req   = 3'b000;
    #1;
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_code", {30'd0, code}, 32'd0);
    chk("arst_pend", {29'd0, pending}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Priority: ch0 and ch2 together; ch2 wins.
    req = 3'b101;
    tick(3);
    chk("pri_pend", {29'd0, pending}, 32'h5);
    chk("pri_code", {30'd0, code}, 32'd3);
    pulse_ack();
    chk("pri_insvc", {29'd0, in_service}, 32'h4);
    chk("pri_pend2", {29'd0, pending}, 32'h1);
    chk("pri_irq0", {31'd0, irq}, 32'd0);
    pulse_eret();
    chk("pri_eret_insvc", {29'd0, in_service}, 32'd0);
    chk("pri_ch0_code", {30'd0, code}, 32'd1);
    pulse_ack();
    chk("ch0_insvc", {29'd0, in_service}, 32'h1);
    chk("ch0_pend", {29'd0, pending}, 32'd0);
    req = 3'b000;
    tick(3);

    // ch2 arrives while ch0 is in service.
    req = 3'b100;
    tick(3);
    chk("nest_pend", {29'd0, pending}, 32'h4);
`ifdef INT_NEST_EN
    chk("nest_irq", {31'd0, irq}, 32'd1);
    chk("nest_code", {30'd0, code}, 32'd3);
    pulse_ack();
    chk("nest_insvc", {29'd0, in_service}, 32'h5);
    pulse_eret();
    chk("nest_eret1", {29'd0, in_service}, 32'h1);
    pulse_eret();
    chk("nest_eret2", {29'd0, in_service}, 32'd0);
`else
    chk("nonest_irq", {31'd0, irq}, 32'd0);
    chk("nonest_code", {30'd0, code}, 32'd0);
    tick(2);
    chk("nonest_hold_irq", {31'd0, irq}, 32'd0);
    pulse_eret();
    chk("nonest_eret_insvc", {29'd0, in_service}, 32'd0);
    chk("nonest_eret_irq", {31'd0, irq}, 32'd1);
    chk("nonest_eret_code", {30'd0, code}, 32'd3);
    pulse_ack();
    chk("nonest_insvc", {29'd0, in_service}, 32'h4);
    pulse_eret();
    chk("nonest_eret2", {29'd0, in_service}, 32'd0);
`endif
    chk("nest_pend_done", {29'd0, pending}, 32'd0);
    req = 3'b000;
    tick(3);

    // Masking and global enable keep pending intact.
    mask = 3'b100;
    req  = 3'b100;
    tick(3);
    chk("mask_pend", {29'd0, pending}, 32'h4);
    chk("mask_irq", {31'd0, irq}, 32'd0);
    mask = 3'b000;
    #1;
    chk("unmask_irq", {31'd0, irq}, 32'd1);
    chk("unmask_code", {30'd0, code}, 32'd3);
    ie = 1'b0;
    #1;
    chk("ie0_irq", {31'd0, irq}, 32'd0);
    pulse_ack();
    chk("ack_noirq_pend", {29'd0, pending}, 32'h4);
    chk("ack_noirq_insvc", {29'd0, in_service}, 32'd0);
    pulse_eret();
    chk("eret_idle_insvc", {29'd0, in_service}, 32'd0);
    chk("eret_idle_pend", {29'd0, pending}, 32'h4);
    ie = 1'b1;
    pulse_ack();
    chk("ie1_ack_insvc", {29'd0, in_service}, 32'h4);
    pulse_eret();
    req = 3'b000;
    tick(3);

    // New ch1 edge lands in the same cycle as the ack of ch1.
    req = 3'b010;
    tick(3);
    chk("bnd_code", {30'd0, code}, 32'd2);
    req = 3'b000;
    tick(3);
    req = 3'b010;
    tick(2);
    pulse_ack();
    chk("bnd_pend", {29'd0, pending}, 32'h2);
    chk("bnd_insvc", {29'd0, in_service}, 32'h2);
    pulse_eret();
    chk("bnd_eret_insvc", {29'd0, in_service}, 32'd0);
    chk("bnd_refire_code", {30'd0, code}, 32'd2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
